// File: rtl/dmem_arb_pkg.sv
// Shared types and default bus widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, loader and data-memory signals of the arbiter, grouped as one bundle.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = dmem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = dmem_arb_pkg::DATA_W
);

  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_ack;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_rdata, ld_ack,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters and memory side
  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_rdata, ld_ack,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage and the loader,
// with registered ownership, bounded loader bursts and a loader anti-starvation wait.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = dmem_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W      = dmem_arb_pkg::DATA_W,
  parameter int unsigned MAX_BURST   = 8,
  parameter int unsigned LD_WAIT_MAX = 16
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned WW = $clog2(LD_WAIT_MAX + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  localparam logic [WW-1:0] WAIT_SAT  = WW'(LD_WAIT_MAX);
  localparam logic [BW-1:0] BURST_SAT = BW'(MAX_BURST);

  owner_t state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;

  logic              cpu_req;
  logic              wait_sat;
  logic              burst_done;
  logic              mem_read;
  logic              mem_write;
  logic              cpu_stall;
  logic              ld_ack;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  assign cpu_req    = bus.cpu_read | bus.cpu_write;
  assign wait_sat   = (wait_cnt_q == WAIT_SAT);
  // The beat in flight counts toward the bound, hence burst_cnt+1.
  assign burst_done = (({1'b0, burst_cnt_q} + 1'b1) >= {1'b0, BURST_SAT});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OWN_CPU;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OWN_CPU: if (bus.ld_req && (!cpu_req || wait_sat))     state_d = OWN_LD;
      OWN_LD:  if (!bus.ld_req || (cpu_req && burst_done))   state_d = OWN_CPU;
      default: state_d = OWN_CPU;
    endcase
  end

  // Both counters restart from zero on any ownership change.
  always_comb begin
    wait_cnt_d  = '0;
    burst_cnt_d = '0;
    if (state_d == state_q) begin
      if (state_q == OWN_CPU) begin
        if (bus.ld_req) wait_cnt_d = wait_sat ? wait_cnt_q : wait_cnt_q + 1'b1;
      end else if (bus.ld_req) begin
        burst_cnt_d = (burst_cnt_q == BURST_SAT) ? burst_cnt_q : burst_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_mux  = bus.cpu_addr;
    wdata_mux = bus.cpu_wdata;
    cpu_stall = 1'b0;
    ld_ack    = 1'b0;
    unique case (state_q)
      OWN_CPU: begin
        mem_read  = bus.cpu_read;
        mem_write = bus.cpu_write;
      end
      OWN_LD: begin
        mem_read  = bus.ld_req & ~bus.ld_we;
        mem_write = bus.ld_req &  bus.ld_we;
        addr_mux  = bus.ld_addr;
        wdata_mux = bus.ld_wdata;
        ld_ack    = bus.ld_req;
        cpu_stall = cpu_req;
      end
      default: ;
    endcase
    // Reset masks strobes immediately so an in-flight beat never commits.
    if (rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      cpu_stall = 1'b0;
      ld_ack    = 1'b0;
    end
  end

  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.cpu_stall = cpu_stall;
  assign bus.ld_ack    = ld_ack;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.ld_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed schedules push expected grants,
// a negedge monitor pops and compares them against what the arbiter presents.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    int          cyc;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } want_t;

  want_t cpu_q[$];
  want_t ld_q[$];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MAX_BURST  (8),
    .LD_WAIT_MAX(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // 1 KB data memory owned by the parent: combinational read, write at the edge.
  logic [31:0] mem [256] = '{default: '0};
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic push_cpu(input bit we, input logic [31:0] addr, input logic [31:0] data);
    want_t w;
    w.cyc = cyc; w.we = we; w.addr = addr; w.data = data;
    cpu_q.push_back(w);
  endtask

  task automatic push_ld(input bit we, input logic [31:0] addr, input logic [31:0] data);
    want_t w;
    w.cyc = cyc; w.we = we; w.addr = addr; w.data = data;
    ld_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    want_t w;
    if (!rst) begin
      if ((bus.cpu_read || bus.cpu_write) && !bus.cpu_stall) begin
        if (cpu_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL cpu_unexpected_grant: got grant at cycle %0d expected none", cyc);
        end else begin
          w = cpu_q.pop_front();
          chk("cpu_cycle", 32'(cyc), 32'(w.cyc));
          chk("cpu_mem_addr", bus.mem_addr, w.addr);
          if (w.we) begin
            chk("cpu_mem_write", 32'(bus.mem_write), 32'd1);
            chk("cpu_mem_wdata", bus.mem_wdata, w.data);
          end else begin
            chk("cpu_mem_read", 32'(bus.mem_read), 32'd1);
            chk("cpu_rdata", bus.cpu_rdata, w.data);
          end
        end
      end
      if (bus.ld_ack) begin
        if (ld_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL ld_unexpected_ack: got ack at cycle %0d expected none", cyc);
        end else begin
          w = ld_q.pop_front();
          chk("ld_cycle", 32'(cyc), 32'(w.cyc));
          chk("ld_mem_addr", bus.mem_addr, w.addr);
          if (w.we) begin
            chk("ld_mem_write", 32'(bus.mem_write), 32'd1);
            chk("ld_mem_wdata", bus.mem_wdata, w.data);
          end else begin
            chk("ld_mem_read", 32'(bus.mem_read), 32'd1);
            chk("ld_rdata", bus.ld_rdata, w.data);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int k;
    rst           = 1'b1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b1;
    bus.cpu_addr  = 32'h10;
    bus.cpu_wdata = 32'h5555_5555;
    bus.ld_req    = 1'b1;
    bus.ld_we     = 1'b1;
    bus.ld_addr   = 32'h0;
    bus.ld_wdata  = 32'h0;
    #2;
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_read",  32'(bus.mem_read),  32'd0);
    chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_ld_ack",    32'(bus.ld_ack),    32'd0);
    repeat (2) @(posedge clk);
    #1;
    bus.ld_req    = 1'b0;
    rst           = 1'b0;

    // CPU only: store then load with no stall
    bus.cpu_write = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEAD_BEEF;
    push_cpu(1'b1, 32'h10, 32'hDEAD_BEEF);
    tick();
    bus.cpu_write = 1'b0; bus.cpu_read = 1'b1;
    push_cpu(1'b0, 32'h10, 32'hDEAD_BEEF);
    tick();
    bus.cpu_read = 1'b0;
    tick();

    // Loader with CPU idle: 4 writes, first ack one cycle after request
    for (int o = 0; o <= 5; o++) begin
      if (o < 5) begin
        k = (o == 0) ? 0 : o - 1;
        bus.ld_req = 1'b1; bus.ld_we = 1'b1;
        bus.ld_addr = 32'h100 + 32'(4 * k); bus.ld_wdata = 32'hA000_0000 + 32'(k);
        if (o >= 1) push_ld(1'b1, bus.ld_addr, bus.ld_wdata);
      end else begin
        bus.ld_req = 1'b0;
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      bus.cpu_read = 1'b1; bus.cpu_addr = 32'h100 + 32'(4 * i);
      push_cpu(1'b0, bus.cpu_addr, 32'hA000_0000 + 32'(i));
      tick();
    end
    bus.cpu_read = 1'b0;
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 32'h108;
    tick();
    push_ld(1'b0, 32'h108, 32'hA000_0002);
    tick();
    bus.ld_req = 1'b0;
    tick();
    tick();

    // Starvation bound: CPU reads continuously, loader waits LD_WAIT_MAX+1 cycles
    bus.cpu_read = 1'b1; bus.cpu_addr = 32'h10;
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 32'h200; bus.ld_wdata = 32'h1111_1111;
    for (int o = 0; o <= 19; o++) begin
      if (o <= 16) push_cpu(1'b0, 32'h10, 32'hDEAD_BEEF);
      if (o == 17) begin
        push_ld(1'b1, 32'h200, 32'h1111_1111);
        bus.cpu_addr = 32'h200;
      end
      if (o == 18) bus.ld_req = 1'b0;
      if (o == 19) push_cpu(1'b0, 32'h200, 32'h1111_1111);
      tick();
    end
    bus.cpu_read = 1'b0;
    tick();

    // Burst bound: 20 beats, 8 acked while the CPU waits, CPU gets one access
    for (int o = 0; o <= 24; o++) begin
      if (o >= 23) begin
        bus.ld_req = 1'b0;
      end else begin
        if (o == 0)       k = 0;
        else if (o <= 8)  k = o - 1;
        else if (o <= 10) k = 8;
        else              k = o - 3;
        bus.ld_req = 1'b1; bus.ld_we = 1'b1;
        bus.ld_addr = 32'h300 + 32'(4 * k); bus.ld_wdata = 32'hB0 + 32'(k);
        if ((o >= 1 && o <= 8) || (o >= 11)) push_ld(1'b1, bus.ld_addr, bus.ld_wdata);
      end
      bus.cpu_read = (o >= 1 && o <= 9);
      bus.cpu_addr = 32'h300;
      if (o == 9) push_cpu(1'b0, 32'h300, 32'hB0);
      tick();
    end
    bus.cpu_read = 1'b1; bus.cpu_addr = 32'h31C;
    push_cpu(1'b0, 32'h31C, 32'hB7);
    tick();
    bus.cpu_addr = 32'h34C;
    push_cpu(1'b0, 32'h34C, 32'hC3);
    tick();
    bus.cpu_read = 1'b0;
    tick();

    // Reset during the third beat of a write burst
    for (int o = 0; o <= 2; o++) begin
      k = (o == 0) ? 0 : o - 1;
      bus.ld_req = 1'b1; bus.ld_we = 1'b1;
      bus.ld_addr = 32'h380 + 32'(4 * k); bus.ld_wdata = 32'hC0 + 32'(k);
      if (o >= 1) push_ld(1'b1, bus.ld_addr, bus.ld_wdata);
      tick();
    end
    bus.ld_addr = 32'h388; bus.ld_wdata = 32'hC2;
    bus.cpu_read = 1'b1; bus.cpu_addr = 32'h384;
    #1;
    chk("midburst_ack_before_rst",   32'(bus.ld_ack),    32'd1);
    chk("midburst_stall_before_rst", 32'(bus.cpu_stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("midburst_ack_in_rst",   32'(bus.ld_ack),    32'd0);
    chk("midburst_write_in_rst", 32'(bus.mem_write), 32'd0);
    chk("midburst_stall_in_rst", 32'(bus.cpu_stall), 32'd0);
    tick();
    bus.ld_req = 1'b0; bus.cpu_read = 1'b0;
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.cpu_read = 1'b1; bus.cpu_addr = 32'h388 - 32'(4 * i);
      push_cpu(1'b0, bus.cpu_addr, (i == 0) ? 32'h0 : 32'hC0 + 32'(2 - i));
      tick();
    end
    bus.cpu_read = 1'b0;
    tick();
    tick();

    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    chk("ld_q_drained",  32'(ld_q.size()),  32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
